// File: rtl/spi_sram_target.sv
// SPI mode-0 target bridging a serial read/write command stream to a byte-wide SRAM port.
// All SPI inputs are resynchronised into clk; spi_clk must stay high/low for >= SCK_MIN_HALF clk.
module spi_sram_target #(
    parameter int unsigned ADDR_BITS    = 16,
    parameter int unsigned SCK_MIN_HALF = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_clk,
    input  logic                 spi_select,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    output logic                 active
);

    localparam int unsigned RX_W  = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam int unsigned CNT_W = $clog2(RX_W);
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [7:0]  CMD_WRITE = 8'h02;

    // Read data lands 2 clk after the rise is seen; the following fall must come later.
    if (SCK_MIN_HALF < 3) begin : g_cfg_check
        $error("spi_sram_target: SCK_MIN_HALF must be at least 3");
    end

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    state_t               state, state_nxt;
    logic                 sck_s1, sck_s2, sck_q;
    logic                 sel_s1, sel_s2, sel_q;
    logic                 mosi_s1, mosi_s2;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [RX_W-2:0]      rx, rx_nxt;
    logic [RX_W-1:0]      rx_shift;
    logic                 wr_intent, wr_intent_nxt;
    logic [7:0]           tx, tx_nxt;
    logic [7:0]           tx_buf, tx_buf_nxt;
    logic                 boundary, boundary_nxt;
    logic                 rd_pend;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic                 miso_nxt, re_nxt, we_nxt;
    logic [7:0]           wdata_nxt;
    logic                 sck_rise, sck_fall, sel_fall;

    assign sck_rise = sck_s2 & ~sck_q;
    assign sck_fall = ~sck_s2 & sck_q;
    assign sel_fall = ~sel_s2 & sel_q;
    assign rx_shift = {rx, mosi_s2};

    // Select resets low, so a frame already running at reset release never shows a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_q   <= 1'b0;
            sel_s1  <= 1'b0;
            sel_s2  <= 1'b0;
            sel_q   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_clk;
            sck_s2  <= sck_s1;
            sck_q   <= sck_s2;
            sel_s1  <= spi_select;
            sel_s2  <= sel_s1;
            sel_q   <= sel_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rx        <= '0;
            wr_intent <= 1'b0;
            tx        <= '0;
            tx_buf    <= '0;
            boundary  <= 1'b0;
            rd_pend   <= 1'b0;
            spi_miso  <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx        <= rx_nxt;
            wr_intent <= wr_intent_nxt;
            tx        <= tx_nxt;
            tx_buf    <= tx_buf_nxt;
            boundary  <= boundary_nxt;
            rd_pend   <= mem_re;
            spi_miso  <= miso_nxt;
            mem_addr  <= addr_nxt;
            mem_re    <= re_nxt;
            mem_we    <= we_nxt;
            mem_wdata <= wdata_nxt;
            active    <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rx_nxt        = rx;
        wr_intent_nxt = wr_intent;
        tx_nxt        = tx;
        tx_buf_nxt    = tx_buf;
        boundary_nxt  = boundary;
        miso_nxt      = spi_miso;
        addr_nxt      = mem_addr;
        re_nxt        = 1'b0;
        we_nxt        = 1'b0;
        wdata_nxt     = mem_wdata;

        if (rd_pend) tx_buf_nxt = mem_rdata;
        // Address advances the cycle after a write strobe so the strobe sees the old address.
        if (mem_we) addr_nxt = mem_addr + ADDR_BITS'(1);

        if (state != IDLE && sel_s2) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            boundary_nxt = 1'b0;
            miso_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_fall) begin
                        state_nxt = CMD;
                        cnt_nxt   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_nxt  = rx_shift[RX_W-2:0];
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt = '0;
                            if (rx_shift[7:0] == CMD_READ) begin
                                state_nxt     = ADDR;
                                wr_intent_nxt = 1'b0;
                            end else if (rx_shift[7:0] == CMD_WRITE) begin
                                state_nxt     = ADDR;
                                wr_intent_nxt = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        rx_nxt  = rx_shift[RX_W-2:0];
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ADDR_BITS - 1)) begin
                            cnt_nxt  = '0;
                            addr_nxt = ADDR_BITS'(rx_shift);
                            if (wr_intent) begin
                                state_nxt = WRITE;
                            end else begin
                                state_nxt    = READ;
                                re_nxt       = 1'b1;
                                boundary_nxt = 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    // Prefetch on the 8th rise; tx_buf is swapped in at the following fall.
                    if (sck_rise) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt      = '0;
                            addr_nxt     = mem_addr + ADDR_BITS'(1);
                            re_nxt       = 1'b1;
                            boundary_nxt = 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (boundary) begin
                            miso_nxt     = tx_buf[7];
                            tx_nxt       = {tx_buf[6:0], 1'b0};
                            boundary_nxt = 1'b0;
                        end else begin
                            miso_nxt = tx[7];
                            tx_nxt   = {tx[6:0], 1'b0};
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise) begin
                        rx_nxt  = rx_shift[RX_W-2:0];
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt   = '0;
                            we_nxt    = 1'b1;
                            wdata_nxt = rx_shift[7:0];
                        end
                    end
                end
                IGNORE: begin
                    state_nxt = IGNORE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// Scoreboard bench for spi_sram_target: bit-banged SPI initiator plus a byte memory backend model.
module tb_spi_sram_target;

    localparam int unsigned AW   = 16;
    localparam int unsigned HALF = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_clk = 1'b0;
    logic          spi_select = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [7:0]    mem_rdata = 8'h00;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          active;

    spi_sram_target #(.ADDR_BITS(AW), .SCK_MIN_HALF(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_select (spi_select),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .active     (active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    int            n_vec = 0;
    int            n_bad = 0;
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [7:0]    bmem[int];
    int            we_cnt = 0;
    int            re_cnt = 0;
    int            miso_hi = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backend model and strobe scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t e;
        if (mem_re && mem_we) check("re_we_overlap", 32'({mem_re, mem_we}), 32'(0));
        if (mem_we) begin
            we_cnt++;
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("we_addr", 32'(mem_addr), 32'(e.a));
                check("we_data", 32'(mem_wdata), 32'(e.d));
            end
        end
        if (mem_re) begin
            re_cnt++;
            if (exp_rd.size() > 0) check("re_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            mem_rdata = bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : 8'h00;
        end
        if (spi_miso) miso_hi++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: MOSI set while clock low, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            wait_clk(HALF);
            r[i] = spi_miso;
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic frame_start();
        spi_select = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_select = 1'b1;
        wait_clk(3 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [AW-1:0] a);
        logic [7:0] r;
        xfer(cmd, r);
        xfer(a[15:8], r);
        xfer(a[7:0], r);
    endtask

    initial begin
        logic [7:0]    r;
        logic [7:0]    d0, d1, d2;
        logic [AW-1:0] ra;
        int            w0, r0, m0;

        wait_clk(3);
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        check("rst_miso", 32'(spi_miso), 32'(0));
        check("rst_strobes", 32'({mem_re, mem_we}), 32'(0));
        check("rst_wdata", 32'(mem_wdata), 32'(0));
        rst_n = 1'b1;
        wait_clk(4);

        // Two-byte write
        w0 = we_cnt;
        exp_wr.push_back('{a: 16'h1234, d: 8'hA5});
        exp_wr.push_back('{a: 16'h1235, d: 8'h5A});
        frame_start();
        check("active_hi", 32'(active), 32'(1));
        send_hdr(8'h02, 16'h1234);
        xfer(8'hA5, r);
        xfer(8'h5A, r);
        frame_end();
        check("wr_count", 32'(we_cnt - w0), 32'(2));
        check("wr_left", 32'(exp_wr.size()), 32'(0));
        check("wr_active_lo", 32'(active), 32'(0));

        // Two-byte read with prefetch of the third address
        r0 = re_cnt;
        bmem[16'h0010] = 8'h3C;
        bmem[16'h0011] = 8'hC3;
        exp_rd.push_back(16'h0010);
        exp_rd.push_back(16'h0011);
        exp_rd.push_back(16'h0012);
        frame_start();
        send_hdr(8'h03, 16'h0010);
        xfer(8'h00, r);
        check("rd_byte0", 32'(r), 32'(8'h3C));
        xfer(8'h00, r);
        check("rd_byte1", 32'(r), 32'(8'hC3));
        frame_end();
        check("rd_count", 32'(re_cnt - r0), 32'(3));
        check("rd_left", 32'(exp_rd.size()), 32'(0));
        check("rd_miso_idle", 32'(spi_miso), 32'(0));

        // Address wrap at the top of memory
        w0 = we_cnt;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        exp_wr.push_back('{a: 16'hFFFF, d: d0});
        exp_wr.push_back('{a: 16'h0000, d: d1});
        frame_start();
        send_hdr(8'h02, 16'hFFFF);
        xfer(d0, r);
        xfer(d1, r);
        frame_end();
        check("wrap_count", 32'(we_cnt - w0), 32'(2));

        // Unknown command: 32 further clocks with no effect
        w0 = we_cnt;
        r0 = re_cnt;
        m0 = miso_hi;
        frame_start();
        xfer(8'h9F, r);
        for (int i = 0; i < 4; i++) xfer(8'hFF, r);
        frame_end();
        check("ign_we", 32'(we_cnt - w0), 32'(0));
        check("ign_re", 32'(re_cnt - r0), 32'(0));
        check("ign_miso", 32'(miso_hi - m0), 32'(0));

        d0 = 8'($urandom);
        bmem[16'h0200] = d0;
        exp_rd.push_back(16'h0200);
        exp_rd.push_back(16'h0201);
        frame_start();
        send_hdr(8'h03, 16'h0200);
        xfer(8'h00, r);
        check("post_ign_rd", 32'(r), 32'(d0));
        frame_end();
        check("post_ign_left", 32'(exp_rd.size()), 32'(0));

        // Partial byte discarded when select rises
        w0 = we_cnt;
        exp_wr.push_back('{a: 16'h0100, d: 8'h77});
        frame_start();
        send_hdr(8'h02, 16'h0100);
        xfer(8'h77, r);
        spi_bits(8'hFF, 5, r);
        wait_clk(HALF);
        spi_select = 1'b1;
        wait_clk(3);
        check("abort_active", 32'(active), 32'(0));
        check("abort_miso", 32'(spi_miso), 32'(0));
        wait_clk(2 * HALF);
        check("abort_we", 32'(we_cnt - w0), 32'(1));

        // Reset pulse during a read address phase
        w0 = we_cnt;
        r0 = re_cnt;
        frame_start();
        xfer(8'h03, r);
        xfer(8'h00, r);
        spi_bits(8'h50, 4, r);
        rst_n = 1'b0;
        #1;
        check("mrst_addr", 32'(mem_addr), 32'(0));
        check("mrst_active", 32'(active), 32'(0));
        check("mrst_strobes", 32'({mem_re, mem_we, spi_miso}), 32'(0));
        wait_clk(1);
        rst_n = 1'b1;
        spi_bits(8'h00, 4, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        check("mrst_stay_idle", 32'(active), 32'(0));
        frame_end();
        check("mrst_we", 32'(we_cnt - w0), 32'(0));
        check("mrst_re", 32'(re_cnt - r0), 32'(0));

        // Random three-byte burst read after the reset
        ra = 16'($urandom_range(16'h0300, 16'hFF00));
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        bmem[int'(ra)] = d0;
        bmem[int'(ra) + 1] = d1;
        bmem[int'(ra) + 2] = d2;
        for (int i = 0; i < 4; i++) exp_rd.push_back(ra + 16'(i));
        frame_start();
        send_hdr(8'h03, ra);
        xfer(8'h00, r);
        check("burst_b0", 32'(r), 32'(d0));
        xfer(8'h00, r);
        check("burst_b1", 32'(r), 32'(d1));
        xfer(8'h00, r);
        check("burst_b2", 32'(r), 32'(d2));
        frame_end();
        check("burst_left", 32'(exp_rd.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_sram_target.md
SPI_SRAM_TARGET -- requirements
Module: spi_sram_target

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, meaning the address width received on the bus and driven on mem_addr.
REQ-002 SHALL have parameter SCK_MIN_HALF, default 4, meaning the minimum spi_clk high or low time in clk cycles that the design supports.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_clk  input  1  SPI serial clock from the initiator, asynchronous to clk.
REQ-006 spi_select  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  serial data from the initiator.
REQ-008 spi_miso  output  1  serial data to the initiator.
REQ-009 mem_addr  output  ADDR_BITS  byte address of the memory backend.
REQ-010 mem_re  output  1  one-cycle read strobe.
REQ-011 mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
REQ-012 mem_we  output  1  one-cycle write strobe.
REQ-013 mem_wdata  output  8  write data, qualified by mem_we.
REQ-014 active  output  1  high while a transaction is selected and in progress.

Function
REQ-015 spi_clk, spi_select and spi_mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals.
REQ-016 Protocol SHALL be SPI mode 0: MOSI sampled on spi_clk rise, MSB-first, with spi_miso updated on spi_clk fall.
REQ-017 The frame SHALL be: 8-bit command, then ADDR_BITS address bits MSB-first, then data bytes until spi_select rises.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, READ, WRITE and IGNORE.
REQ-019 A spi_select fall in IDLE SHALL enter CMD and clear the bit counter; active SHALL go high the next cycle.
REQ-020 After 8 CMD bits, command 0x03 SHALL enter ADDR with read intent, 0x02 SHALL enter ADDR with write intent, and any other value SHALL enter IGNORE.
REQ-021 After the last address bit is sampled, the design SHALL load the address register: read intent pulses mem_re with mem_addr = received address and enters READ; write intent enters WRITE.
REQ-022 In READ, mem_rdata SHALL load the TX shift register 1 clk after mem_re, and its MSB SHALL appear on spi_miso at the next spi_clk fall.
REQ-023 In READ, on the rise sampling bit 7 of each byte, the address SHALL increment and mem_re SHALL pulse for the next byte (prefetch), with data loaded at the byte-boundary fall.
REQ-024 In WRITE, each 8th sampled bit SHALL pulse mem_we for 1 clk with mem_addr = current address and mem_wdata = assembled byte, then increment the address.
REQ-025 Address increment SHALL wrap from 2^ADDR_BITS-1 to 0.
REQ-026 A spi_select rise in any state SHALL return to IDLE within 3 clk; a partial write byte SHALL be discarded with no mem_we; a pending prefetch SHALL be dropped; spi_miso SHALL go to 0.
REQ-027 In IGNORE, spi_clk edges SHALL be ignored, spi_miso SHALL hold 0, and there SHALL be no mem_re or mem_we.
REQ-028 mem_re and mem_we SHALL never be high in the same cycle, and each SHALL be high for at most 1 clk per byte.
REQ-029 spi_miso SHALL be 0 outside READ.
REQ-030 Correct operation SHALL be required only when spi_clk high and low times are each ≥ SCK_MIN_HALF clk.
REQ-031 spi_select edges coincident with spi_clk edges SHALL give select priority.

Reset
REQ-032 When rst_n is low, all of the following SHALL apply asynchronously: state=IDLE; spi_miso=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0; active=0; counters, shift registers and synchronizers cleared.
REQ-033 rst_n assertion mid-frame SHALL abort the frame with no memory strobe.
REQ-034 After rst_n deassertion, the design SHALL ignore the frame in progress until spi_select goes high then low.

Verification
REQ-035 Write 0x02, addr 0x1234, bytes 0xA5, 0x5A -> mem_we pulses at 0x1234/0xA5 then 0x1235/0x5A, exactly 2 pulses.
REQ-036 Read 0x03, addr 0x0010, backend returns 0x3C then 0xC3 -> spi_miso shifts 0x3C then 0xC3 MSB-first; mem_re at 0x0010, 0x0011, 0x0012 (prefetch).
REQ-037 Write at addr 0xFFFF with 2 bytes -> second mem_we at address 0x0000.
REQ-038 Command 0x9F followed by 32 clocks -> no mem_re or mem_we, spi_miso=0 throughout; next 0x03 frame works normally.
REQ-039 Write 0x02, addr 0x0100, 0x77, then 5 bits, then select rises -> exactly 1 mem_we (0x0100/0x77), state IDLE and active=0 within 3 clk.
REQ-040 rst_n low for 1 clk during a read address phase -> all outputs 0 immediately; the same frame's remaining clocks produce no strobes.
